// File: rtl/hazard_detector_pkg.sv
// Shared definitions for the hazard detector and the EX-stage forwarding unit.
package hazard_detector_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 3;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_ID_EX  = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_src_t;

endpackage

// File: rtl/hazard_detector_if.sv
// ID-stage hazard interface; HAZARD_STATS_EN adds the statistics counters.
interface hazard_detector_if #(
    parameter int unsigned MEM_ADDR_SIZE = 5
);
    import hazard_detector_pkg::*;

    logic [REG_ADDR_W-1:0]    i_if_id_rs;
    logic [REG_ADDR_W-1:0]    i_if_id_rt;
    logic                     i_id_uses_rt;
    logic                     i_id_is_branch;
    logic                     i_id_is_halt;
    logic                     i_branch_taken;
    logic                     i_id_ex_wb;
    logic                     i_id_ex_mem_read;
    logic [MEM_ADDR_SIZE-1:0] i_id_ex_wb_addr;
    logic                     i_ex_mem_mem_read;
    logic [MEM_ADDR_SIZE-1:0] i_ex_mem_wb_addr;
    logic                     o_pc_write;
    logic                     o_if_id_write;
    logic                     o_if_id_flush;
    logic                     o_id_ex_bubble;
    logic                     o_stall;
    logic                     o_halted;
`ifdef HAZARD_STATS_EN
    logic [31:0]              o_stall_cycles;
    logic [15:0]              o_flush_count;
`endif

    // Pipeline side
    modport master (
`ifdef HAZARD_STATS_EN
        input  o_stall_cycles, o_flush_count,
`endif
        output i_if_id_rs, i_if_id_rt, i_id_uses_rt, i_id_is_branch, i_id_is_halt,
               i_branch_taken, i_id_ex_wb, i_id_ex_mem_read, i_id_ex_wb_addr,
               i_ex_mem_mem_read, i_ex_mem_wb_addr,
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_stall, o_halted
    );

    // Hazard detector side
    modport slave (
`ifdef HAZARD_STATS_EN
        output o_stall_cycles, o_flush_count,
`endif
        input  i_if_id_rs, i_if_id_rt, i_id_uses_rt, i_id_is_branch, i_id_is_halt,
               i_branch_taken, i_id_ex_wb, i_id_ex_mem_read, i_id_ex_wb_addr,
               i_ex_mem_mem_read, i_ex_mem_wb_addr,
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_stall, o_halted
    );

endinterface

// File: rtl/hazard_detector_match.sv
// Combinational required-stall count for the instruction in ID.
module hazard_match
    import hazard_detector_pkg::*;
#(
    parameter int unsigned MEM_ADDR_SIZE = 5
) (
    input  logic [REG_ADDR_W-1:0]    i_rs,
    input  logic [REG_ADDR_W-1:0]    i_rt,
    input  logic                     i_uses_rt,
    input  logic                     i_is_branch,
    input  logic                     i_id_ex_wb,
    input  logic                     i_id_ex_mem_read,
    input  logic [MEM_ADDR_SIZE-1:0] i_id_ex_wb_addr,
    input  logic                     i_ex_mem_mem_read,
    input  logic [MEM_ADDR_SIZE-1:0] i_ex_mem_wb_addr,
    output logic [1:0]               o_stall_n
);

    // r0 is never a real dependency
    function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                   input logic [MEM_ADDR_SIZE-1:0] a);
        return (a == MEM_ADDR_SIZE'(x)) && (x != REG_ZERO);
    endfunction

    logic w_src_id_ex;
    logic w_src_ex_mem;
    logic w_need_two;
    logic w_need_one;

    assign w_src_id_ex  = match(i_rs, i_id_ex_wb_addr)  || (i_uses_rt && match(i_rt, i_id_ex_wb_addr));
    assign w_src_ex_mem = match(i_rs, i_ex_mem_wb_addr) || (i_uses_rt && match(i_rt, i_ex_mem_wb_addr));

    assign w_need_two = i_is_branch && i_id_ex_mem_read && w_src_id_ex;
    assign w_need_one = (!i_is_branch && i_id_ex_mem_read && w_src_id_ex)
                     || (i_is_branch && i_id_ex_wb && !i_id_ex_mem_read && w_src_id_ex)
                     || (i_is_branch && i_ex_mem_mem_read && w_src_ex_mem);

    assign o_stall_n = w_need_two ? 2'd2 : (w_need_one ? 2'd1 : 2'd0);

endmodule

// File: rtl/hazard_detector.sv
// Stall/flush/halt-drain controller beside the ID stage.
// Optional feature macro: HAZARD_STATS_EN (stall-cycle and flush counters).
module hazard_detector
    import hazard_detector_pkg::*;
#(
    parameter int unsigned MEM_ADDR_SIZE = 5,
    parameter int unsigned DRAIN_CYCLES  = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_detector_if.slave  bus
);

    hazard_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_n;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_stall;
    logic             w_halted;

    hazard_match #(.MEM_ADDR_SIZE(MEM_ADDR_SIZE)) u_match (
        .i_rs              (bus.i_if_id_rs),
        .i_rt              (bus.i_if_id_rt),
        .i_uses_rt         (bus.i_id_uses_rt),
        .i_is_branch       (bus.i_id_is_branch),
        .i_id_ex_wb        (bus.i_id_ex_wb),
        .i_id_ex_mem_read  (bus.i_id_ex_mem_read),
        .i_id_ex_wb_addr   (bus.i_id_ex_wb_addr),
        .i_ex_mem_mem_read (bus.i_ex_mem_mem_read),
        .i_ex_mem_wb_addr  (bus.i_ex_mem_wb_addr),
        .o_stall_n         (w_n)
    );

    // A single-cycle hazard stays in RUN: ID/EX advances and the hazard clears itself
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_n == 2'd2) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= STALL;
                    end else if (w_n == 2'd0 && bus.i_id_is_halt) begin
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                        r_state <= DRAIN;
                    end
                end
                STALL: begin
                    if (r_cnt == '0) r_state <= RUN;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                DRAIN: begin
                    if (r_cnt == '0) r_state <= HALTED;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: r_state <= HALTED;
            endcase
        end
    end

    // Stall outranks a redirect; the branch re-presents once the stall ends
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_stall        = 1'b0;
        w_halted       = 1'b0;
        if (i_reset) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_n != 2'd0 || bus.i_id_is_halt) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        w_stall        = 1'b1;
                    end else begin
                        w_if_id_flush  = bus.i_branch_taken;
                    end
                end
                STALL, DRAIN: begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_stall        = 1'b1;
                end
                default: begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_halted       = 1'b1;
                end
            endcase
        end
    end

    assign bus.o_pc_write     = w_pc_write;
    assign bus.o_if_id_write  = w_if_id_write;
    assign bus.o_if_id_flush  = w_if_id_flush;
    assign bus.o_id_ex_bubble = w_id_ex_bubble;
    assign bus.o_stall        = w_stall;
    assign bus.o_halted       = w_halted;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Saturating counters; drain cycles are not hazard stalls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_state == RUN || r_state == STALL) && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_if_id_flush && r_flush_count != '1)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign bus.o_stall_cycles = r_stall_cycles;
    assign bus.o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_detector.sv
// Directed bench for hazard_detector; output vector is {pc_write, if_id_write, flush, bubble, stall, halted}.
module tb_hazard_detector;

    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_FLUSH = 6'b111000;
    localparam logic [5:0] V_STALL = 6'b000110;
    localparam logic [5:0] V_RST   = 6'b000100;
    localparam logic [5:0] V_HALT  = 6'b000101;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_detector_if #(.MEM_ADDR_SIZE(5)) bus ();

    hazard_detector #(.MEM_ADDR_SIZE(5), .DRAIN_CYCLES(3)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.o_pc_write, bus.o_if_id_write, bus.o_if_id_flush,
                    bus.o_id_ex_bubble, bus.o_stall, bus.o_halted});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_chk(input string tag, input logic [5:0] exp);
        #2;
        chk(tag, outs(), 32'(exp));
    endtask

    task automatic clear_in();
        bus.i_if_id_rs        = '0;
        bus.i_if_id_rt        = '0;
        bus.i_id_uses_rt      = 1'b0;
        bus.i_id_is_branch    = 1'b0;
        bus.i_id_is_halt      = 1'b0;
        bus.i_branch_taken    = 1'b0;
        bus.i_id_ex_wb        = 1'b0;
        bus.i_id_ex_mem_read  = 1'b0;
        bus.i_id_ex_wb_addr   = '0;
        bus.i_ex_mem_mem_read = 1'b0;
        bus.i_ex_mem_wb_addr  = '0;
    endtask

    task automatic set_id_ex(input logic wb, input logic ld, input logic [4:0] addr);
        bus.i_id_ex_wb       = wb;
        bus.i_id_ex_mem_read = ld;
        bus.i_id_ex_wb_addr  = addr;
    endtask

    task automatic set_id(input logic br, input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
        bus.i_id_is_branch = br;
        bus.i_if_id_rs     = rs;
        bus.i_if_id_rt     = rt;
        bus.i_id_uses_rt   = use_rt;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        settle_chk("reset_outputs", V_RST);
        step();
        settle_chk("reset_held", V_RST);
        rst = 1'b0;
        settle_chk("run_idle", V_RUN);
`ifdef HAZARD_STATS_EN
        chk("stats_stall_after_reset", bus.o_stall_cycles, 32'd0);
`endif
        step();

        // Load-use: LW r5 in EX, ADD r1,r5,r2 in ID
        set_id_ex(1'b1, 1'b1, 5'd5);
        set_id(1'b0, 5'd5, 5'd2, 1'b1);
        settle_chk("load_use_stall", V_STALL);
        step();
        set_id_ex(1'b0, 1'b0, 5'd0);
        settle_chk("load_use_released", V_RUN);
`ifdef HAZARD_STATS_EN
        chk("stats_stall_one", bus.o_stall_cycles, 32'd1);
`endif
        set_id_ex(1'b1, 1'b1, 5'd5);
        set_id(1'b0, 5'd3, 5'd5, 1'b1);
        settle_chk("load_use_rt", V_STALL);
        bus.i_id_uses_rt = 1'b0;
        settle_chk("load_use_rt_unused", V_RUN);
        set_id_ex(1'b1, 1'b1, 5'd0);
        set_id(1'b0, 5'd0, 5'd0, 1'b1);
        settle_chk("load_use_r0", V_RUN);
        clear_in();
        step();

        // Load-branch with a pending redirect: two STALL cycles after detect
        set_id_ex(1'b1, 1'b1, 5'd3);
        set_id(1'b1, 5'd3, 5'd4, 1'b1);
        bus.i_branch_taken = 1'b1;
        settle_chk("ld_br_detect", V_STALL);
        step();
        set_id_ex(1'b0, 1'b0, 5'd0);
        settle_chk("ld_br_stall1", V_STALL);
        step();
        settle_chk("ld_br_stall2", V_STALL);
        step();
        settle_chk("ld_br_resume_flush", V_FLUSH);
        step();
        clear_in();
        settle_chk("after_ld_br", V_RUN);

        // ALU-producer branch, r0 destination, non-branch ALU consumer
        set_id_ex(1'b1, 1'b0, 5'd7);
        set_id(1'b1, 5'd7, 5'd0, 1'b1);
        settle_chk("alu_br_stall", V_STALL);
        step();
        set_id_ex(1'b1, 1'b0, 5'd0);
        settle_chk("alu_br_r0", V_RUN);
        set_id_ex(1'b1, 1'b0, 5'd7);
        bus.i_id_is_branch = 1'b0;
        settle_chk("alu_nonbranch_fwd", V_RUN);

        // Load in EX/MEM feeding an ID branch
        clear_in();
        bus.i_ex_mem_mem_read = 1'b1;
        bus.i_ex_mem_wb_addr  = 5'd9;
        set_id(1'b1, 5'd9, 5'd1, 1'b0);
        settle_chk("exmem_ld_br", V_STALL);
        bus.i_id_is_branch = 1'b0;
        settle_chk("exmem_ld_nonbranch", V_RUN);
        clear_in();
        step();

        // Plain taken branch
        set_id(1'b1, 5'd1, 5'd2, 1'b1);
        bus.i_branch_taken = 1'b1;
        settle_chk("taken_flush", V_FLUSH);
        step();
        bus.i_branch_taken = 1'b0;
        settle_chk("taken_cleared", V_RUN);
`ifdef HAZARD_STATS_EN
        chk("stats_flush_count", 32'(bus.o_flush_count), 32'd2);
`endif
        clear_in();

        // HALT behind a load-use hazard, then drain and hold
        set_id_ex(1'b1, 1'b1, 5'd5);
        set_id(1'b0, 5'd5, 5'd0, 1'b0);
        bus.i_id_is_halt   = 1'b1;
        bus.i_branch_taken = 1'b1;
        settle_chk("halt_blocked", V_STALL);
        step();
        set_id_ex(1'b0, 1'b0, 5'd0);
        settle_chk("halt_accept", V_STALL);
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            settle_chk($sformatf("drain_%0d", i), V_STALL);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            settle_chk($sformatf("halted_%0d", i), V_HALT);
            step();
        end
        rst = 1'b1;
        settle_chk("halted_reset", V_RST);
        step();
        rst = 1'b0;
        settle_chk("halted_reset_run", V_RUN);
        step();

        // Reset in the first STALL-state cycle of a load-branch stall
        set_id_ex(1'b1, 1'b1, 5'd3);
        set_id(1'b1, 5'd3, 5'd4, 1'b1);
        settle_chk("rst_ld_br_detect", V_STALL);
        step();
        clear_in();
        settle_chk("rst_ld_br_stall", V_STALL);
        rst = 1'b1;
        settle_chk("rst_mid_stall", V_RST);
        step();
        rst = 1'b0;
        settle_chk("rst_no_residual0", V_RUN);
`ifdef HAZARD_STATS_EN
        chk("stats_stall_cleared", bus.o_stall_cycles, 32'd0);
`endif
        step();
        settle_chk("rst_no_residual1", V_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
